// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared ALUOp, forwarding-select and bubble constants for the ID/EX stage
package id_ex_stage_pkg;

  // ALU operation encodings shared with the decoder and the ALU
  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_NOR = 4'd6,
    ALU_SLT = 4'd7,
    ALU_SLL = 4'd8,
    ALU_SRL = 4'd9,
    ALU_SRA = 4'd10,
    ALU_LUI = 4'd11
  } alu_op_e;

  // Operand source select inside the forwarding mux
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  // Side-effecting control bits carried into EX
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

  // A bubble carries no side effects and a NOP ALU operation
  localparam ctrl_t   CTRL_BUBBLE  = '0;
  localparam alu_op_e ALUOP_BUBBLE = ALU_NOP;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - per-operand EX/MEM and MEM/WB forwarding select
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] i_idx,
  input  logic [DATA_W-1:0]  i_rf_data,
  input  logic               i_exm_regwrite,
  input  logic [RADDR_W-1:0] i_exm_rd,
  input  logic [DATA_W-1:0]  i_exm_result,
  input  logic               i_mwb_regwrite,
  input  logic [RADDR_W-1:0] i_mwb_rd,
  input  logic [DATA_W-1:0]  i_mwb_result,
  output logic [DATA_W-1:0]  o_data
);

  logic [1:0] w_sel;

  // Youngest producer wins; register 0 is hard-wired and never forwarded
  always_comb begin
    w_sel = FWD_RF;
    if (i_exm_regwrite && (i_exm_rd != '0) && (i_exm_rd == i_idx)) begin
      w_sel = FWD_EXM;
    end else if (i_mwb_regwrite && (i_mwb_rd != '0) && (i_mwb_rd == i_idx)) begin
      w_sel = FWD_MWB;
    end
  end

  // Steer the selected source onto the operand
  always_comb begin
    o_data = i_rf_data;
    case (w_sel)
      FWD_EXM: o_data = i_exm_result;
      FWD_MWB: o_data = i_mwb_result;
      default: o_data = i_rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with hazard detection and forwarding (optional ID_EX_PERF_EN counters)
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [4:0]         id_shamt,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic               id_alusrc,
  input  logic               id_shsel,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_memtoreg,
  input  logic               exm_regwrite,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0]  exm_result,
  input  logic               mwb_regwrite,
  input  logic [RADDR_W-1:0] mwb_rd,
  input  logic [DATA_W-1:0]  mwb_result,
  input  logic               flush_i,
  input  logic               hold_i,
  output logic               stall_o,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               ex_valid,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_memtoreg
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]        perf_luse_o,
  output logic [31:0]        perf_flush_o
`endif
);

  logic               r_valid;
  logic [RADDR_W-1:0] r_rs;
  logic [RADDR_W-1:0] r_rt;
  logic [RADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]  r_rs_data;
  logic [DATA_W-1:0]  r_rt_data;
  logic [DATA_W-1:0]  r_imm;
  logic [4:0]         r_shamt;
  logic [ALUOP_W-1:0] r_aluop;
  logic               r_alusrc;
  logic               r_shsel;
  ctrl_t              r_ctrl;

  logic               w_load_use;
  logic [DATA_W-1:0]  w_fwd_rs;
  logic [DATA_W-1:0]  w_fwd_rt;

  // A load in EX whose result ID needs cannot be forwarded in time
  assign w_load_use = r_valid & r_ctrl.memread & (r_rd != '0) & id_valid &
                      ((r_rd == id_rs) | (r_rd == id_rt));

  // Flush turns the would-be stall into a bubble, so it does not hold ID
  assign stall_o = hold_i | (w_load_use & ~flush_i);

  // Pipeline register: hold > flush > load-use bubble > load
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid   <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_shamt   <= '0;
      r_aluop   <= ALUOP_W'(ALUOP_BUBBLE);
      r_alusrc  <= 1'b0;
      r_shsel   <= 1'b0;
      r_ctrl    <= CTRL_BUBBLE;
    end else if (hold_i) begin
      r_valid <= r_valid;
    end else if (flush_i || w_load_use) begin
      r_valid  <= 1'b0;
      r_aluop  <= ALUOP_W'(ALUOP_BUBBLE);
      r_alusrc <= 1'b0;
      r_shsel  <= 1'b0;
      r_ctrl   <= CTRL_BUBBLE;
    end else begin
      r_valid   <= id_valid;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_shamt   <= id_shamt;
      r_aluop   <= id_aluop;
      r_alusrc  <= id_alusrc;
      r_shsel   <= id_shsel;
      r_ctrl    <= '{regwrite: id_regwrite, memread: id_memread,
                     memwrite: id_memwrite, memtoreg: id_memtoreg};
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rs (
    .i_idx          (r_rs),
    .i_rf_data      (r_rs_data),
    .i_exm_regwrite (exm_regwrite),
    .i_exm_rd       (exm_rd),
    .i_exm_result   (exm_result),
    .i_mwb_regwrite (mwb_regwrite),
    .i_mwb_rd       (mwb_rd),
    .i_mwb_result   (mwb_result),
    .o_data         (w_fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rt (
    .i_idx          (r_rt),
    .i_rf_data      (r_rt_data),
    .i_exm_regwrite (exm_regwrite),
    .i_exm_rd       (exm_rd),
    .i_exm_result   (exm_result),
    .i_mwb_regwrite (mwb_regwrite),
    .i_mwb_rd       (mwb_rd),
    .i_mwb_result   (mwb_result),
    .o_data         (w_fwd_rt)
  );

  assign alu_a         = r_shsel  ? {{(DATA_W-5){1'b0}}, r_shamt} : w_fwd_rs;
  assign alu_b         = r_alusrc ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign alu_op        = r_aluop;
  assign ex_valid      = r_valid;
  assign ex_rd         = r_rd;
  assign ex_regwrite   = r_ctrl.regwrite;
  assign ex_memread    = r_ctrl.memread;
  assign ex_memwrite   = r_ctrl.memwrite;
  assign ex_memtoreg   = r_ctrl.memtoreg;

`ifdef ID_EX_PERF_EN
  logic [31:0] r_perf_luse;
  logic [31:0] r_perf_flush;

  // Saturating counts of load-use bubbles and accepted flushes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perf_luse  <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_load_use && !hold_i && !flush_i && (r_perf_luse != 32'hFFFF_FFFF)) begin
        r_perf_luse <= r_perf_luse + 32'd1;
      end
      if (flush_i && !hold_i && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_luse_o  = r_perf_luse;
  assign perf_flush_o = r_perf_flush;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed scoreboard bench for id_ex_stage (optional ID_EX_PERF_EN checks)
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_aluop;
  logic        id_alusrc, id_shsel;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        exm_regwrite;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        mwb_regwrite;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_result;
  logic        flush_i, hold_i;
  logic        stall_o;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_op;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_luse_o, perf_flush_o;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .RADDR_W(5), .ALUOP_W(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .id_shamt      (id_shamt),
    .id_aluop      (id_aluop),
    .id_alusrc     (id_alusrc),
    .id_shsel      (id_shsel),
    .id_regwrite   (id_regwrite),
    .id_memread    (id_memread),
    .id_memwrite   (id_memwrite),
    .id_memtoreg   (id_memtoreg),
    .exm_regwrite  (exm_regwrite),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_regwrite  (mwb_regwrite),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .flush_i       (flush_i),
    .hold_i        (hold_i),
    .stall_o       (stall_o),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_store_data (ex_store_data),
    .ex_regwrite   (ex_regwrite),
    .ex_memread    (ex_memread),
    .ex_memwrite   (ex_memwrite),
    .ex_memtoreg   (ex_memtoreg)
`ifdef ID_EX_PERF_EN
    ,
    .perf_luse_o   (perf_luse_o),
    .perf_flush_o  (perf_flush_o)
`endif
  );

  typedef struct {
    string       tag;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] store;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic        chk_data;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                      input logic [4:0] rd, input logic [3:0] ctrl, input logic cd);
    exp_t e;
    e.tag = tag; e.valid = v; e.op = op; e.a = a; e.b = b; e.store = st;
    e.rd = rd; e.ctrl = ctrl; e.chk_data = cd;
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_assert++;
    assert (q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({e.tag, "_valid"}, {31'b0, ex_valid}, {31'b0, e.valid});
      chk({e.tag, "_op"}, {28'b0, alu_op}, {28'b0, e.op});
      chk({e.tag, "_ctrl"}, {28'b0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
          {28'b0, e.ctrl});
      if (e.chk_data) begin
        chk({e.tag, "_a"}, alu_a, e.a);
        chk({e.tag, "_b"}, alu_b, e.b);
        chk({e.tag, "_store"}, ex_store_data, e.store);
        chk({e.tag, "_rd"}, {27'b0, ex_rd}, {27'b0, e.rd});
      end
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] sh, input logic [3:0] op,
                        input logic asrc, input logic ssel, input logic rw, input logic mr,
                        input logic mw, input logic mtr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_shamt = sh; id_aluop = op; id_alusrc = asrc; id_shsel = ssel;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mtr;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0, 0, 0, 0, 0);
    exm_regwrite = 0; exm_rd = 0; exm_result = 0;
    mwb_regwrite = 0; mwb_rd = 0; mwb_result = 0;
    flush_i = 0; hold_i = 0;

    repeat (2) edge_sample();
    push("reset", 0, ALU_NOP, 0, 0, 0, 0, 4'b0000, 1);
    pop_check();
    chk("reset_stall", {31'b0, stall_o}, 32'd0);
    rstn = 1'b1;

    // ADD r3,r1,r2
    set_id(1, 1, 2, 3, 32'd5, 32'd7, 0, 0, ALU_ADD, 0, 0, 1, 0, 0, 0);
    push("add", 1, ALU_ADD, 32'd5, 32'd7, 32'd7, 3, 4'b1000, 1);
    edge_sample();
    pop_check();

    // Both forwarding sources hit r1: EX/MEM wins
    exm_regwrite = 1; exm_rd = 1; exm_result = 32'h10;
    mwb_regwrite = 1; mwb_rd = 1; mwb_result = 32'h20;
    #1;
    push("fwd_both", 1, ALU_ADD, 32'h10, 32'd7, 32'd7, 3, 4'b1000, 1);
    pop_check();
    exm_regwrite = 0;
    #1;
    push("fwd_mwb", 1, ALU_ADD, 32'h20, 32'd7, 32'd7, 3, 4'b1000, 1);
    pop_check();
    exm_regwrite = 1; exm_rd = 0; mwb_regwrite = 0;
    #1;
    push("fwd_none", 1, ALU_ADD, 32'd5, 32'd7, 32'd7, 3, 4'b1000, 1);
    pop_check();
    exm_rd = 2; exm_result = 32'h77;
    #1;
    push("fwd_rt", 1, ALU_ADD, 32'd5, 32'h77, 32'h77, 3, 4'b1000, 1);
    pop_check();

    // Source index 0 must not be forwarded even when EX/MEM writes r0
    set_id(1, 0, 2, 3, 32'h99, 32'd7, 0, 0, ALU_ADD, 0, 0, 1, 0, 0, 0);
    exm_regwrite = 1; exm_rd = 0; exm_result = 32'hDEAD;
    push("rs_zero", 1, ALU_ADD, 32'h99, 32'd7, 32'd7, 3, 4'b1000, 1);
    edge_sample();
    pop_check();
    exm_regwrite = 0;

    // LW r4, 8(r1) followed by a consumer of r4
    set_id(1, 1, 0, 4, 32'h100, 0, 32'd8, 0, ALU_ADD, 1, 0, 1, 1, 0, 1);
    push("lw", 1, ALU_ADD, 32'h100, 32'd8, 32'd0, 4, 4'b1101, 1);
    edge_sample();
    pop_check();
    set_id(1, 5, 4, 6, 32'h55, 32'hBAD, 0, 0, ALU_ADD, 0, 0, 1, 0, 0, 0);
    #1;
    chk("luse_stall", {31'b0, stall_o}, 32'd1);
    push("luse_bubble", 0, ALU_NOP, 0, 0, 0, 0, 4'b0000, 0);
    edge_sample();
    pop_check();
    chk("luse_stall_clear", {31'b0, stall_o}, 32'd0);
    mwb_regwrite = 1; mwb_rd = 4; mwb_result = 32'h4444;
    push("luse_retry", 1, ALU_ADD, 32'h55, 32'h4444, 32'h4444, 6, 4'b1000, 1);
    edge_sample();
    pop_check();
    mwb_regwrite = 0;

    // SLL r2,r5,3 with r5 forwarded from EX/MEM
    set_id(1, 0, 5, 2, 0, 32'd5, 0, 5'd3, ALU_SLL, 0, 1, 1, 0, 0, 0);
    exm_regwrite = 1; exm_rd = 5; exm_result = 32'h50;
    push("sll", 1, ALU_SLL, 32'd3, 32'h50, 32'h50, 2, 4'b1000, 1);
    edge_sample();
    pop_check();
    exm_regwrite = 0;

    // LUI r7, 0x1234
    set_id(1, 0, 0, 7, 0, 0, 32'h1234, 0, ALU_LUI, 1, 0, 1, 0, 0, 0);
    push("lui", 1, ALU_LUI, 32'd0, 32'h1234, 32'd0, 7, 4'b1000, 1);
    edge_sample();
    pop_check();

    // flush and hold together: EX frozen, then the flush lands as a bubble
    set_id(1, 1, 2, 8, 32'h11, 32'h22, 0, 0, ALU_SUB, 0, 0, 1, 0, 0, 0);
    flush_i = 1; hold_i = 1;
    #1;
    chk("hold_stall", {31'b0, stall_o}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      push("hold_keep", 1, ALU_LUI, 32'd0, 32'h1234, 32'd0, 7, 4'b1000, 1);
      edge_sample();
      pop_check();
    end
    hold_i = 0;
    #1;
    chk("flush_stall", {31'b0, stall_o}, 32'd0);
    push("flush_bubble", 0, ALU_NOP, 0, 0, 0, 0, 4'b0000, 0);
    edge_sample();
    pop_check();
    flush_i = 0;
`ifdef ID_EX_PERF_EN
    chk("perf_flush", perf_flush_o, 32'd1);
    chk("perf_luse", perf_luse_o, 32'd1);
`endif

    // Reset asserted mid-cycle while a load-use stall is pending
    set_id(1, 1, 0, 4, 32'h100, 0, 32'd8, 0, ALU_ADD, 1, 0, 1, 1, 0, 1);
    push("lw2", 1, ALU_ADD, 32'h100, 32'd8, 32'd0, 4, 4'b1101, 1);
    edge_sample();
    pop_check();
    set_id(1, 5, 4, 6, 32'h55, 32'hBAD, 0, 0, ALU_ADD, 0, 0, 1, 0, 0, 0);
    #1;
    chk("luse_stall2", {31'b0, stall_o}, 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    push("mid_reset", 0, ALU_NOP, 0, 0, 0, 0, 4'b0000, 1);
    pop_check();
    chk("mid_reset_stall", {31'b0, stall_o}, 32'd0);
`ifdef ID_EX_PERF_EN
    chk("perf_flush_rst", perf_flush_o, 32'd0);
    chk("perf_luse_rst", perf_luse_o, 32'd0);
`endif
    edge_sample();
    rstn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register feeding the ALU in the pipelined CPU.
- Latches decoded operands and control from ID, detects load-use hazards, and inserts bubbles on stall or flush.
- Drives the ALU's A, B and ALUOp through an EX/MEM and MEM/WB forwarding network.
- Shift ops take A = zero-extended shamt; LUI/immediate ops take B = immediate.

Parameters:
- DATA_W, 32, datapath width.
- RADDR_W, 5, register-index width.
- ALUOP_W, 4, ALUOp width; encodings from shared ctrl encode definitions.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  RADDR_W  source and destination indices; id_rd is the already-resolved write register.
- id_rs_data, id_rt_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  extended immediate.
- id_shamt  in  5  shift amount.
- id_aluop  in  ALUOP_W  ALU operation.
- id_alusrc  in  1  B from immediate.
- id_shsel  in  1  A from shamt.
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  control bits.
- exm_regwrite  in  1  EX/MEM forwarding source: write enable.
- exm_rd  in  RADDR_W  EX/MEM forwarding source: destination.
- exm_result  in  DATA_W  EX/MEM forwarding source: result.
- mwb_regwrite, mwb_rd, mwb_result  in  1/RADDR_W/DATA_W  MEM/WB forwarding source.
- flush_i  in  1  kill the instruction entering EX (branch/jump taken).
- hold_i  in  1  downstream busy; freeze EX.
- stall_o  out  1  ID/IF must hold this cycle.
- alu_a, alu_b  out  DATA_W  ALU operands.
- alu_op  out  ALUOP_W  ALU operation.
- ex_valid  out  1  EX holds a real instruction.
- ex_rd  out  RADDR_W  EX destination.
- ex_store_data  out  DATA_W  forwarded rt value, used for SW.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  control bits passed to EX.

Behaviour:
- Reset (rstn low, async): all registered fields 0. Results: ex_valid=0, alu_op=ALU_NOP, alu_a=alu_b=0, all control bits 0, stall_o=0.
- Register update at rising clk, in priority order:
  - hold_i=1: all fields keep their value.
  - flush_i=1: load a bubble (valid and control bits 0, alu_op=ALU_NOP).
  - load_use=1: load a bubble.
  - otherwise: load all ID fields; ex_valid<=id_valid.
- hold_i overrides flush_i. Upstream keeps flush_i asserted until a cycle with hold_i=0.
- load_use (combinational) = ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt).
- stall_o = hold_i | (load_use & ~flush_i).
- Forwarding (combinational, on registered rs/rt), per operand:
  - EX/MEM result if exm_regwrite & exm_rd!=0 & exm_rd==idx.
  - else MEM/WB result under the same rule with mwb.
  - else the registered register-file data.
  - EX/MEM wins when both match. Index 0 is never forwarded.
- alu_a = id_shsel registered ? {27'b0, shamt} : forwarded rs.
- alu_b = alusrc registered ? imm : forwarded rt.
- ex_store_data = forwarded rt, regardless of alusrc.
- Bubble outputs: alu_a and alu_b may carry stale data. ex_valid=0 and all control bits 0 guarantee no side effects.
- Latency: one cycle ID→EX. Operands update the same cycle a forwarding source changes.
- Reset mid-stall: all state cleared; stall_o falls immediately, since ex_valid=0.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - Adds two 32-bit saturating counters: perf_luse_o counts cycles with load_use & ~hold_i & ~flush_i; perf_flush_o counts accepted flushes (flush_i & ~hold_i).
  - Both are cleared by rstn and stick at 32'hFFFF_FFFF.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Shared package/header: ALUOp encodings (ALU_NOP…ALU_LUI), forwarding-select encoding FWD_RF=2'b00, FWD_EXM=2'b01, FWD_MWB=2'b10, and bubble control constants.
- One sub-module, fwd_mux: index, register data, both forwarding sources in; selected data out. Instantiated twice, for rs and rt.

Test Plan:
- Reset then idle: rstn low mid-cycle → all outputs 0 and alu_op=ALU_NOP immediately, without waiting for a clock edge.
- ADD r3,r1,r2 with rs_data=5, rt_data=7, no forwarding sources matching → next cycle alu_a=5, alu_b=7, alu_op=ALU_ADD, ex_valid=1.
- Double forward: exm writes r1=0x10 and mwb writes r1=0x20 → alu_a=0x10. Then exm_regwrite drops → alu_a=0x20. With exm_rd=0 → no forwarding.
- Load-use: EX holds LW r4 and ID uses r4 as rt → stall_o=1 for one cycle, then a bubble (ex_valid=0). The next cycle the instruction enters and takes its operand from mwb.
- SLL r2,r5,3 with id_shsel=1 → alu_a=3, alu_b=forwarded r5. LUI imm=0x1234 with alusrc=1 → alu_b=0x1234.
- flush_i and hold_i together for 2 cycles, then hold_i drops → EX unchanged during the hold, then a bubble loads. With ID_EX_PERF_EN defined, perf_flush_o=1.
